// File: rtl/count_pair_alu.sv
// Operates on two sampled counter values (ADD/SUB/XOR/CMP) and queues the results in a small FIFO.
// A saturating counter tracks how many CMP commands saw equal operands.
module count_pair_alu #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int MCW   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         count_a,
   input  logic [WIDTH-1:0]         count_b,
   input  logic                     cmd_valid,
   input  logic [1:0]               cmd_op,
   output logic                     cmd_ready,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output logic                     res_flag,
   output logic [1:0]               res_op,
   output logic [MCW-1:0]           match_cnt,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_XOR = 2'b10,
      OP_CMP = 2'b11
   } op_e;

   logic [WIDTH-1:0] r_mem_data [DEPTH];
   logic             r_mem_flag [DEPTH];
   logic [1:0]       r_mem_op   [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic [MCW-1:0]   r_match;

   op_e              w_op;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_xor;
   logic [WIDTH-1:0] w_data;
   logic             w_flag;
   logic             w_ready;
   logic             w_valid;
   logic             w_push;
   logic             w_pop;
   logic             w_match_hit;

   // Ready depends on stored occupancy only, never on res_ready.
   assign w_ready     = (r_level < LW'(DEPTH));
   assign w_valid     = (r_level != '0);
   assign w_push      = cmd_valid && w_ready && !reset;
   assign w_pop       = w_valid && res_ready && !reset;
   assign w_op        = op_e'(cmd_op);
   assign w_match_hit = w_push && (w_op == OP_CMP) && (count_a == count_b);

   always_comb begin
      w_sum  = {1'b0, count_a} + {1'b0, count_b};
      w_xor  = count_a ^ count_b;
      w_data = '0;
      w_flag = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_data = w_sum[WIDTH-1:0];
            w_flag = w_sum[WIDTH];
         end
         OP_SUB: begin
            w_data = count_a - count_b;
            w_flag = (count_a < count_b);
         end
         OP_XOR: begin
            w_data = w_xor;
            w_flag = (w_xor == '0);
         end
         OP_CMP: begin
            w_data = (count_a > count_b) ? count_a : count_b;
            w_flag = (count_a == count_b);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= w_data;
         r_mem_flag[r_wr_ptr] <= w_flag;
         r_mem_op[r_wr_ptr]   <= cmd_op;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_match  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_match_hit && (r_match != '1)) begin
            r_match <= r_match + 1'b1;
         end
      end
   end

   // Head fields read as zero whenever the FIFO is empty.
   assign cmd_ready  = w_ready;
   assign res_valid  = w_valid;
   assign res_data   = w_valid ? r_mem_data[r_rd_ptr] : '0;
   assign res_flag   = w_valid ? r_mem_flag[r_rd_ptr] : 1'b0;
   assign res_op     = w_valid ? r_mem_op[r_rd_ptr]   : 2'b00;
   assign match_cnt  = r_match;
   assign fifo_level = r_level;

endmodule

// File: tb/tb_count_pair_alu.sv
// Scoreboard bench for count_pair_alu: expected results are queued at push and compared at pop.
module tb_count_pair_alu;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] count_a, count_b;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic       cmd_ready;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_flag;
   logic [1:0] res_op;
   logic [7:0] match_cnt;
   logic [2:0] fifo_level;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          exp_match = 0;
   logic [10:0] q[$];
   logic        p_push, p_pop;
   logic [10:0] p_val, e, h;

   localparam logic [7:0] TA [4] = '{8'hF0, 8'h05, 8'h3C, 8'h12};
   localparam logic [7:0] TB [4] = '{8'h20, 8'h07, 8'h3C, 8'h40};
   localparam logic [7:0] TD [4] = '{8'h10, 8'hFE, 8'h00, 8'h40};
   localparam logic       TF [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

   always #5 clk = ~clk;

   count_pair_alu #(.WIDTH(8), .DEPTH(4), .MCW(8)) dut (
      .clk(clk), .reset(reset), .count_a(count_a), .count_b(count_b),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_flag(res_flag), .res_op(res_op), .match_cnt(match_cnt),
      .fifo_level(fifo_level)
   );

   function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      int   ia, ib, r;
      logic f;
      ia = int'(a);
      ib = int'(b);
      case (op)
         2'd0: begin r = ia + ib; f = (r > 255); r = r % 256; end
         2'd1: begin f = (ia < ib); r = (ia - ib + 256) % 256; end
         2'd2: begin r = ia ^ ib; f = (r == 0); end
         default: begin r = (ia > ib) ? ia : ib; f = (ia == ib); end
      endcase
      return {r[7:0], f, op};
   endfunction

   // Observe handshakes for the coming edge, update the scoreboard, then advance one clock.
   task automatic cycle(output logic pushed, output logic popped, output logic [10:0] pv);
      pushed = (reset === 1'b0) && (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
      popped = (reset === 1'b0) && (res_valid === 1'b1) && (res_ready === 1'b1);
      pv     = {res_data, res_flag, res_op};
      if (reset === 1'b1) begin
         q.delete();
         exp_match = 0;
      end else if (pushed) begin
         q.push_back(model(count_a, count_b, cmd_op));
         if (cmd_op == 2'd3 && count_a == count_b && exp_match < 255) exp_match++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; count_a = 8'h01; count_b = 8'h02; res_ready = 1'b1;
      cycle(p_push, p_pop, p_val);
      cycle(p_push, p_pop, p_val);
      n_checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else n_pass++;
      n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", res_valid); else n_pass++;
      n_checks++; if ({res_data, res_flag, res_op} !== 11'd0) $display("FAIL reset_head got %h want 0", {res_data, res_flag, res_op}); else n_pass++;
      n_checks++; if (match_cnt !== 8'd0) $display("FAIL reset_match got %0d want 0", match_cnt); else n_pass++;
      reset = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
      cycle(p_push, p_pop, p_val);
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else n_pass++;
   endtask

   task automatic test_ops;
      for (int i = 0; i < 4; i++) begin
         count_a = TA[i]; count_b = TB[i]; cmd_op = 2'(i); cmd_valid = 1'b1; res_ready = 1'b0;
         cycle(p_push, p_pop, p_val);
         cmd_valid = 1'b0;
         n_checks++; if (res_valid !== 1'b1) $display("FAIL op%0d_valid got %b want 1", i, res_valid); else n_pass++;
         n_checks++; if ({res_data, res_flag, res_op} !== {TD[i], TF[i], 2'(i)})
            $display("FAIL op%0d_head got %h want %h", i, {res_data, res_flag, res_op}, {TD[i], TF[i], 2'(i)}); else n_pass++;
         n_checks++; if (fifo_level !== 3'(q.size())) $display("FAIL op%0d_level got %0d want %0d", i, fifo_level, q.size()); else n_pass++;
         res_ready = 1'b1;
         cycle(p_push, p_pop, p_val);
         res_ready = 1'b0;
         n_checks++;
         if (!p_pop || q.size() == 0) $display("FAIL op%0d_pop got pop=%b want pop=1", i, p_pop);
         else begin
            e = q.pop_front();
            if (p_val !== e) $display("FAIL op%0d_popval got %h want %h", i, p_val, e); else n_pass++;
         end
         n_checks++; if (res_valid !== 1'b0 || fifo_level !== 3'd0) $display("FAIL op%0d_empty got valid=%b level=%0d want 0/0", i, res_valid, fifo_level); else n_pass++;
         n_checks++; if (match_cnt !== 8'(exp_match)) $display("FAIL op%0d_match got %0d want %0d", i, match_cnt, exp_match); else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      res_ready = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         count_a = 8'($urandom); count_b = 8'($urandom); cmd_op = 2'($urandom);
         cycle(p_push, p_pop, p_val);
         n_checks++; if (p_push !== 1'b1) $display("FAIL b2b_accept%0d got %b want 1", i, p_push); else n_pass++;
      end
      n_checks++; if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) $display("FAIL b2b_full got ready=%b level=%0d want 0/4", cmd_ready, fifo_level); else n_pass++;
      count_a = 8'hAA; count_b = 8'h55; cmd_op = 2'd1;
      cycle(p_push, p_pop, p_val);
      n_checks++; if (p_push !== 1'b0) $display("FAIL b2b_held got %b want 0", p_push); else n_pass++;
      h = {res_data, res_flag, res_op};
      cycle(p_push, p_pop, p_val);
      n_checks++; if ({res_data, res_flag, res_op} !== h || h !== q[0]) $display("FAIL b2b_stall_head got %h want %h", {res_data, res_flag, res_op}, q[0]); else n_pass++;
      res_ready = 1'b1;
      cycle(p_push, p_pop, p_val);
      res_ready = 1'b0;
      n_checks++;
      if (!p_pop || p_push || q.size() == 0) $display("FAIL b2b_pop got pop=%b push=%b want 1/0", p_pop, p_push);
      else begin
         e = q.pop_front();
         if (p_val !== e) $display("FAIL b2b_popval got %h want %h", p_val, e); else n_pass++;
      end
      cycle(p_push, p_pop, p_val);
      cmd_valid = 1'b0;
      n_checks++; if (p_push !== 1'b1) $display("FAIL b2b_fifth got %b want 1", p_push); else n_pass++;
      res_ready = 1'b1;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
         cycle(p_push, p_pop, p_val);
         if (p_pop) begin
            n_checks++; e = q.pop_front();
            if (p_val !== e) $display("FAIL b2b_drain got %h want %h", p_val, e); else n_pass++;
         end
      end
      res_ready = 1'b0;
      n_checks++; if (q.size() != 0 || res_valid !== 1'b0) $display("FAIL b2b_drained got left=%0d valid=%b want 0/0", q.size(), res_valid); else n_pass++;
   endtask

   task automatic test_full_stream;
      res_ready = 1'b0; cmd_valid = 1'b1;
      for (int c = 0; c < 8 && cmd_ready === 1'b1; c++) begin
         count_a = 8'($urandom); count_b = 8'($urandom); cmd_op = 2'($urandom);
         cycle(p_push, p_pop, p_val);
      end
      n_checks++; if (fifo_level !== 3'd4) $display("FAIL stream_fill got %0d want 4", fifo_level); else n_pass++;
      res_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         count_a = 8'($urandom); count_b = 8'($urandom); cmd_op = 2'($urandom);
         cycle(p_push, p_pop, p_val);
         n_checks++;
         if (!p_pop || q.size() == 0) $display("FAIL stream_pop%0d got pop=%b want 1", c, p_pop);
         else begin
            e = q.pop_front();
            if (p_val !== e) $display("FAIL stream_val%0d got %h want %h", c, p_val, e); else n_pass++;
         end
         n_checks++; if (fifo_level !== 3'(q.size())) $display("FAIL stream_level%0d got %0d want %0d", c, fifo_level, q.size()); else n_pass++;
      end
      cmd_valid = 1'b0;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
         cycle(p_push, p_pop, p_val);
         if (p_pop) begin
            n_checks++; e = q.pop_front();
            if (p_val !== e) $display("FAIL stream_drain got %h want %h", p_val, e); else n_pass++;
         end
      end
      res_ready = 1'b0;
      n_checks++; if (q.size() != 0 || res_valid !== 1'b0) $display("FAIL stream_drained got left=%0d valid=%b want 0/0", q.size(), res_valid); else n_pass++;
   endtask

   task automatic test_match_sat;
      int accepted;
      reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
      cycle(p_push, p_pop, p_val);
      reset = 1'b0;
      count_a = 8'h00; count_b = 8'h00; cmd_op = 2'd3; cmd_valid = 1'b1; res_ready = 1'b1;
      accepted = 0;
      for (int c = 0; c < 400 && accepted < 300; c++) begin
         cycle(p_push, p_pop, p_val);
         if (p_push) accepted++;
         if (p_pop) begin
            n_checks++; e = q.pop_front();
            if (p_val !== e) $display("FAIL sat_pop got %h want %h", p_val, e); else n_pass++;
         end
         n_checks++; if (match_cnt !== 8'(exp_match)) $display("FAIL sat_count got %0d want %0d", match_cnt, exp_match); else n_pass++;
      end
      cmd_valid = 1'b0;
      n_checks++; if (accepted != 300 || match_cnt !== 8'hFF) $display("FAIL sat_final got acc=%0d cnt=%0d want 300/255", accepted, match_cnt); else n_pass++;
      for (int c = 0; c < 10 && q.size() > 0; c++) begin
         cycle(p_push, p_pop, p_val);
         if (p_pop) begin
            n_checks++; e = q.pop_front();
            if (p_val !== e) $display("FAIL sat_drain got %h want %h", p_val, e); else n_pass++;
         end
      end
      n_checks++; if (match_cnt !== 8'hFF) $display("FAIL sat_hold got %0d want 255", match_cnt); else n_pass++;
      reset = 1'b1; res_ready = 1'b0;
      cycle(p_push, p_pop, p_val);
      reset = 1'b0;
      n_checks++; if (match_cnt !== 8'd0 || fifo_level !== 3'd0 || res_valid !== 1'b0)
         $display("FAIL sat_reset got cnt=%0d level=%0d valid=%b want 0/0/0", match_cnt, fifo_level, res_valid); else n_pass++;
   endtask

   task automatic test_reset_mid;
      res_ready = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         count_a = 8'($urandom); count_b = 8'($urandom); cmd_op = 2'($urandom);
         cycle(p_push, p_pop, p_val);
      end
      n_checks++; if (fifo_level !== 3'd3) $display("FAIL mid_fill got %0d want 3", fifo_level); else n_pass++;
      reset = 1'b1; res_ready = 1'b1;
      cycle(p_push, p_pop, p_val);
      reset = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
      n_checks++; if (fifo_level !== 3'd0 || res_valid !== 1'b0 || res_data !== 8'd0 || cmd_ready !== 1'b1)
         $display("FAIL mid_reset got level=%0d valid=%b data=%h ready=%b want 0/0/00/1", fifo_level, res_valid, res_data, cmd_ready); else n_pass++;
      count_a = 8'h01; count_b = 8'h01; cmd_op = 2'd0; cmd_valid = 1'b1;
      cycle(p_push, p_pop, p_val);
      cmd_valid = 1'b0;
      n_checks++; if (res_valid !== 1'b1 || res_data !== 8'h02 || res_flag !== 1'b0)
         $display("FAIL mid_add got valid=%b data=%h flag=%b want 1/02/0", res_valid, res_data, res_flag); else n_pass++;
      res_ready = 1'b1;
      cycle(p_push, p_pop, p_val);
      res_ready = 1'b0;
      n_checks++;
      if (!p_pop || q.size() != 1) $display("FAIL mid_pop got pop=%b queued=%0d want 1/1", p_pop, q.size());
      else begin
         e = q.pop_front();
         if (p_val !== e) $display("FAIL mid_popval got %h want %h", p_val, e); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_back_to_back();
      test_full_stream();
      test_match_sat();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

endmodule
